// File: rtl/multiexp_dispatch_if.sv
// Handshake bundle between the multiexp dispatcher, the core array, the shared point adder and the result sink.
// Pure wiring, zero latency.
// Every stream is valid/ready; adder responses are valid-only and always accepted by the dispatcher.
// Modports: master = dispatcher, slave = surrounding logic (front end, cores, adder, sink).
interface multiexp_dispatch_if #(
    parameter int NUM_CORES   = 4,
    parameter int POINT_BITS  = 512,
    parameter int SCALAR_BITS = 256,
    parameter int RES_BITS    = 768,
    parameter int CNT_BITS    = 32
);
    // job control
    logic                          i_start;
    logic [CNT_BITS-1:0]           i_num_pairs;
    logic                          o_busy;
    // input pair stream
    logic                          i_pair_val;
    logic                          o_pair_rdy;
    logic [POINT_BITS-1:0]         i_pair_point;
    logic [SCALAR_BITS-1:0]        i_pair_scalar;
    // shared core bus
    logic [NUM_CORES-1:0]          o_core_val;
    logic [NUM_CORES-1:0]          i_core_rdy;
    logic [POINT_BITS-1:0]         o_core_point;
    logic [SCALAR_BITS-1:0]        o_core_scalar;
    logic                          o_core_last;
    // per-core partial results
    logic [NUM_CORES-1:0]          i_cres_val;
    logic [NUM_CORES-1:0]          o_cres_rdy;
    logic [NUM_CORES*RES_BITS-1:0] i_cres_point;
    // shared adder
    logic                          o_add_val;
    logic                          i_add_rdy;
    logic [RES_BITS-1:0]           o_add_a;
    logic [RES_BITS-1:0]           o_add_b;
    logic                          i_add_res_val;
    logic [RES_BITS-1:0]           i_add_res;
    // final result
    logic                          o_res_val;
    logic                          i_res_rdy;
    logic [RES_BITS-1:0]           o_res_point;

    modport master (
        input  i_start, i_num_pairs, i_pair_val, i_pair_point, i_pair_scalar,
               i_core_rdy, i_cres_val, i_cres_point, i_add_rdy, i_add_res_val,
               i_add_res, i_res_rdy,
        output o_busy, o_pair_rdy, o_core_val, o_core_point, o_core_scalar,
               o_core_last, o_cres_rdy, o_add_val, o_add_a, o_add_b,
               o_res_val, o_res_point
    );

    modport slave (
        output i_start, i_num_pairs, i_pair_val, i_pair_point, i_pair_scalar,
               i_core_rdy, i_cres_val, i_cres_point, i_add_rdy, i_add_res_val,
               i_add_res, i_res_rdy,
        input  o_busy, o_pair_rdy, o_core_val, o_core_point, o_core_scalar,
               o_core_last, o_cres_rdy, o_add_val, o_add_a, o_add_b,
               o_res_val, o_res_point
    );
endinterface

// File: rtl/multiexp_dispatch.sv
// Deals (point, scalar) pairs round-robin to NUM_CORES multiexp cores, gathers their partials and folds them through the shared adder.
// Latency: pair->core path is combinational; last adder response -> o_res_val 1 cycle; start -> o_busy 1 cycle.
// Backpressure: a stalled target core stalls the whole pair stream; adder and result outputs hold until accepted.
// Ports: i_clk, i_rst (sync, active high), bus = multiexp_dispatch_if.master carrying all streams.
module multiexp_dispatch #(
    parameter int NUM_CORES   = 4,
    parameter int POINT_BITS  = 512,
    parameter int SCALAR_BITS = 256,
    parameter int RES_BITS    = 768,
    parameter int CNT_BITS    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    multiexp_dispatch_if.master   bus
);
    localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int UW = $clog2(NUM_CORES + 1);
    localparam logic [CNT_BITS-1:0] NC_CNT = CNT_BITS'(NUM_CORES);

    typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_COLLECT, S_REDUCE, S_OUTPUT} state_t;
    state_t state, state_nxt;

    logic [CNT_BITS-1:0]  num_pairs, k_cnt, last_from;
    logic [SW-1:0]        sel;
    logic [UW-1:0]        used_cnt, red_idx, b_idx;
    logic [NUM_CORES-1:0] used_mask, got_mask, cres_rdy, cres_acc;
    logic [RES_BITS-1:0]  slot [NUM_CORES];
    logic [RES_BITS-1:0]  acc, add_a, add_b;
    logic                 add_val, add_pend;

    logic [CNT_BITS-1:0]  start_last_from;
    logic [UW-1:0]        start_used;
    logic [NUM_CORES-1:0] start_mask;
    logic                 dispatching, xfer, add_resp, last_add;

    // Job geometry derived from i_num_pairs at start: first "last" index
    // (saturating) and how many cores actually get work.
    always_comb begin
        start_last_from = (bus.i_num_pairs > NC_CNT) ? bus.i_num_pairs - NC_CNT : '0;
        start_used      = (bus.i_num_pairs > NC_CNT) ? UW'(NUM_CORES) : UW'(bus.i_num_pairs);
        start_mask      = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (UW'(c) < start_used) start_mask[c] = 1'b1;
        end
    end

    assign dispatching = (state == S_DISPATCH);
    assign xfer        = dispatching && bus.i_pair_val && bus.i_core_rdy[sel];
    assign cres_rdy    = (state == S_COLLECT) ? (used_mask & ~got_mask) : '0;
    assign cres_acc    = bus.i_cres_val & cres_rdy;
    // Responses only count while a request is in flight; stray pulses are dropped.
    assign add_resp    = (state == S_REDUCE) && add_pend && bus.i_add_res_val;
    assign last_add    = (red_idx == used_cnt - UW'(1));
    // Slot feeding the next adder request: slot 1 on entry to REDUCE, then one past the current.
    assign b_idx       = (state == S_REDUCE) ? red_idx + UW'(1) : UW'(1);

    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_pair_rdy    = dispatching && bus.i_core_rdy[sel];
    assign bus.o_core_point  = dispatching ? bus.i_pair_point  : '0;
    assign bus.o_core_scalar = dispatching ? bus.i_pair_scalar : '0;
    assign bus.o_core_last   = dispatching && (k_cnt >= last_from);
    assign bus.o_cres_rdy    = cres_rdy;
    assign bus.o_add_val     = add_val;
    assign bus.o_add_a       = add_a;
    assign bus.o_add_b       = add_b;
    assign bus.o_res_val     = (state == S_OUTPUT);
    assign bus.o_res_point   = acc;

    always_comb begin
        bus.o_core_val = '0;
        if (dispatching) bus.o_core_val[sel] = bus.i_pair_val;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.i_start)
                            state_nxt = (bus.i_num_pairs == '0) ? S_OUTPUT : S_DISPATCH;
            S_DISPATCH: if (xfer && (k_cnt == num_pairs - CNT_BITS'(1)))
                            state_nxt = S_COLLECT;
            S_COLLECT:  if (got_mask == used_mask)
                            state_nxt = (used_cnt == UW'(1)) ? S_OUTPUT : S_REDUCE;
            S_REDUCE:   if (add_resp && last_add)
                            state_nxt = S_OUTPUT;
            S_OUTPUT:   if (bus.i_res_rdy)
                            state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            num_pairs <= '0;
            k_cnt     <= '0;
            last_from <= '0;
            sel       <= '0;
            used_cnt  <= '0;
            red_idx   <= '0;
            used_mask <= '0;
            got_mask  <= '0;
            acc       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_val   <= 1'b0;
            add_pend  <= 1'b0;
            for (int c = 0; c < NUM_CORES; c++) slot[c] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (bus.i_start) begin
                    num_pairs <= bus.i_num_pairs;
                    last_from <= start_last_from;
                    used_cnt  <= start_used;
                    used_mask <= start_mask;
                    got_mask  <= '0;
                    k_cnt     <= '0;
                    sel       <= '0;
                    acc       <= '0;   // all-zero = point at infinity for an empty job
                end
                S_DISPATCH: if (xfer) begin
                    k_cnt <= k_cnt + CNT_BITS'(1);
                    sel   <= (sel == SW'(NUM_CORES - 1)) ? '0 : sel + SW'(1);
                end
                S_COLLECT: begin
                    got_mask <= got_mask | cres_acc;
                    for (int c = 0; c < NUM_CORES; c++) begin
                        if (cres_acc[c]) slot[c] <= bus.i_cres_point[c*RES_BITS +: RES_BITS];
                    end
                    // All partials were stored on an earlier edge, so slots are stable here.
                    if (got_mask == used_mask) begin
                        acc <= slot[0];
                        if (used_cnt != UW'(1)) begin
                            add_val <= 1'b1;
                            add_a   <= slot[0];
                            add_b   <= slot[b_idx[SW-1:0]];
                            red_idx <= UW'(1);
                        end
                    end
                end
                S_REDUCE: begin
                    if (add_val && bus.i_add_rdy) begin
                        add_val  <= 1'b0;
                        add_pend <= 1'b1;
                    end
                    if (add_resp) begin
                        add_pend <= 1'b0;
                        acc      <= bus.i_add_res;
                        // Chain straight into the next request so the adder sees no idle gap.
                        if (!last_add) begin
                            add_val <= 1'b1;
                            add_a   <= bus.i_add_res;
                            add_b   <= slot[b_idx[SW-1:0]];
                            red_idx <= b_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multiexp_dispatch.sv
// Directed bench for multiexp_dispatch: drives jobs through behavioural cores, adder and sink, checks every handshake.
// Inputs change 1 time unit after posedge, outputs sampled 2 units after posedge.
// Cores, adder and sink apply scripted backpressure and out-of-order returns.
module tb_multiexp_dispatch;
    localparam int NC = 4;
    localparam int RB = 768;

    logic i_clk;
    logic i_rst;
    int   n_checks = 0;
    int   n_errors = 0;

    multiexp_dispatch_if bus ();

    multiexp_dispatch dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [RB-1:0] act, input logic [RB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // A core only returns its partial after the whole stream has been dealt,
    // so no result may ever be offered while the dispatcher drives a core.
    always @(negedge i_clk) begin
        if (!i_rst && |bus.o_core_val) check("cres_in_dispatch", RB'(bus.i_cres_val), '0);
    end

    // Partial of core c carries tag c at bit 200 plus the sum of its scalars.
    function automatic logic [RB-1:0] mk(input int tagsum, input int scal);
        logic [RB-1:0] r;
        r = '0;
        r[200 +: 8] = 8'(tagsum);
        r = r + RB'(scal);
        return r;
    endfunction

    task automatic drive_idle;
        bus.i_start       = 1'b0;
        bus.i_num_pairs   = '0;
        bus.i_pair_val    = 1'b0;
        bus.i_pair_point  = '0;
        bus.i_pair_scalar = '0;
        bus.i_core_rdy    = '0;
        bus.i_cres_val    = '0;
        bus.i_cres_point  = '0;
        bus.i_add_rdy     = 1'b0;
        bus.i_add_res_val = 1'b0;
        bus.i_add_res     = '0;
        bus.i_res_rdy     = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},     RB'(bus.o_busy),      '0);
        check({tag, "_pair_rdy"}, RB'(bus.o_pair_rdy),  '0);
        check({tag, "_core_val"}, RB'(bus.o_core_val),  '0);
        check({tag, "_core_last"},RB'(bus.o_core_last), '0);
        check({tag, "_core_pt"},  RB'(bus.o_core_point),'0);
        check({tag, "_core_sc"},  RB'(bus.o_core_scalar),'0);
        check({tag, "_cres_rdy"}, RB'(bus.o_cres_rdy),  '0);
        check({tag, "_add_val"},  RB'(bus.o_add_val),   '0);
        check({tag, "_add_a"},    bus.o_add_a,          '0);
        check({tag, "_add_b"},    bus.o_add_b,          '0);
        check({tag, "_res_val"},  RB'(bus.o_res_val),   '0);
        check({tag, "_res_pt"},   bus.o_res_point,      '0);
    endtask

    bit aborted;

    task automatic run_job(input int n, input int stall1, input int res_stall,
                           input int r0, input int r1, input int r2, input int r3,
                           input logic [RB-1:0] exp_final, input int exp_adds, input bit abort);
        logic [RB-1:0] part [NC];
        bit            got_last [NC];
        bit            returned [NC];
        int            ret_at [NC];
        logic [RB-1:0] exp_acc, res_hold, resp;
        int cyc, k, stall_left, res_wait, first_d, last_d, timer, adds, unused_rdy, res_first, used, lf;
        bit busy_add, done, have_res, stalled;

        used = (n < NC) ? n : NC;
        lf   = (n > NC) ? n - NC : 0;
        ret_at[0] = r0; ret_at[1] = r1; ret_at[2] = r2; ret_at[3] = r3;
        for (int c = 0; c < NC; c++) begin
            part[c] = mk(c, 0);
            got_last[c] = 1'b0;
            returned[c] = 1'b0;
        end
        cyc = 0; k = 0; stall_left = stall1; res_wait = 0; first_d = -1; last_d = -1;
        timer = 0; adds = 0; unused_rdy = 0; res_first = -1;
        busy_add = 0; done = 0; have_res = 0; aborted = 0;
        exp_acc = '0; res_hold = '0; resp = '0;

        bus.i_start = 1'b1;
        bus.i_num_pairs = 32'(n);
        tick;
        bus.i_start = 1'b0;
        check("busy_rise", RB'(bus.o_busy), RB'(1));

        while (!done && cyc < 400) begin
            // ---- drive ----
            // a start pulse while busy must be ignored
            bus.i_start       = (cyc == 2);
            bus.i_num_pairs   = (cyc == 2) ? 32'd3 : 32'(n);
            bus.i_pair_val    = (k < n);
            bus.i_pair_point  = {256'(k + 100), 256'(k)};
            bus.i_pair_scalar = 256'(k + 1);
            bus.i_core_rdy    = '1;
            stalled = 1'b0;
            if (k == 1 && stall_left > 0) begin
                bus.i_core_rdy[1] = 1'b0;
                stall_left--;
                stalled = 1'b1;
            end
            for (int c = 0; c < NC; c++) begin
                if (c < used) begin
                    bus.i_cres_val[c] = got_last[c] && !returned[c] && (k >= n) && (cyc >= ret_at[c]);
                    bus.i_cres_point[c*RB +: RB] = part[c];
                end else begin
                    // unused cores chatter with junk once the stream is done
                    bus.i_cres_val[c] = (n > 0) && (k >= n);
                    bus.i_cres_point[c*RB +: RB] = '1;
                end
            end
            bus.i_add_rdy     = (cyc % 3 != 0);
            bus.i_add_res_val = busy_add ? (timer == 0) : 1'b1;   // junk pulses while idle
            bus.i_add_res     = busy_add ? resp : '1;
            bus.i_res_rdy     = (res_wait >= res_stall);
            #1;
            // ---- sample ----
            if (k < n) check("pair_rdy", RB'(bus.o_pair_rdy), RB'(bus.i_core_rdy[k % NC]));
            if (stalled) check("stall_val", RB'(bus.o_core_val), RB'(4'b0010));
            for (int c = 0; c < NC; c++) begin
                if (bus.o_core_val[c] && bus.i_core_rdy[c]) begin
                    check("core_sel", RB'(c), RB'(k % NC));
                    check("core_scalar", RB'(bus.o_core_scalar), RB'(k + 1));
                    check("core_point", RB'(bus.o_core_point), RB'({256'(k + 100), 256'(k)}));
                    check("core_last", RB'(bus.o_core_last), RB'(k >= lf));
                    part[c] = part[c] + RB'(k + 1);
                    if (bus.o_core_last) got_last[c] = 1'b1;
                    if (first_d < 0) first_d = cyc;
                    last_d = cyc;
                    k++;
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (bus.o_cres_rdy[c] && c >= used) unused_rdy++;
                if (bus.i_cres_val[c] && bus.o_cres_rdy[c] && c < used) returned[c] = 1'b1;
            end
            if (bus.o_add_val && bus.i_add_rdy) begin
                check("add_overlap", RB'(busy_add), '0);
                if (adds == 0) exp_acc = part[0];
                check("add_a", bus.o_add_a, exp_acc);
                if (adds + 1 < used) begin
                    check("add_b", bus.o_add_b, part[adds + 1]);
                    exp_acc = exp_acc + part[adds + 1];
                end
                adds++;
                busy_add = 1'b1;
                timer = 2;
                resp = bus.o_add_a + bus.o_add_b;
            end else if (busy_add) begin
                if (timer == 0) busy_add = 1'b0;
                else timer--;
            end
            if (bus.o_res_val) begin
                if (!have_res) begin
                    have_res = 1'b1;
                    res_hold = bus.o_res_point;
                    res_first = cyc;
                end else begin
                    check("res_stable", bus.o_res_point, res_hold);
                end
                if (bus.i_res_rdy) begin
                    check("res_point", bus.o_res_point, exp_final);
                    done = 1'b1;
                end
                res_wait++;
            end else if (have_res) begin
                check("res_val_drop", RB'(0), RB'(1));
            end
            if (abort && busy_add) begin
                aborted = 1'b1;
                break;
            end
            tick;
            cyc++;
        end

        if (aborted) return;
        if (!done) begin
            check("timeout", RB'(0), RB'(1));
            return;
        end
        check("pairs_sent", RB'(k), RB'(n));
        check("add_count", RB'(adds), RB'(exp_adds));
        check("unused_rdy", RB'(unused_rdy), '0);
        if (n > 0) check("disp_span", RB'(last_d - first_d), RB'(n - 1 + stall1));
        else       check("n0_latency", RB'(res_first), '0);
        drive_idle();
        tick;
        check("idle_after", RB'(bus.o_busy), '0);
    endtask

    initial begin
        drive_idle();
        i_rst = 1'b1;
        tick;
        tick;
        check_quiet("rst");
        i_rst = 1'b0;
        tick;

        // 8 pairs over 4 cores, no stalls: partials 6,8,10,12 + tags 0..3
        run_job(8, 0, 0, 0, 0, 0, 0, mk(6, 36), 3, 0);
        // 2 pairs: cores 0,1 only, scalars 1+2, tags 0+1
        run_job(2, 0, 0, 0, 0, 0, 0, mk(1, 3), 1, 0);
        // empty job: point at infinity immediately
        run_job(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
        // core 1 stalls 5 cycles at k=1, sink stalls 10 cycles
        run_job(8, 5, 10, 0, 0, 0, 0, mk(6, 36), 3, 0);
        // partials return 3, then 0 and 2 together, then 1
        run_job(4, 0, 0, 8, 10, 8, 6, mk(6, 10), 3, 0);

        // abort while the first add is outstanding
        run_job(4, 0, 0, 0, 0, 0, 0, mk(6, 10), 3, 1);
        check("abort_reached", RB'(aborted), RB'(1));
        drive_idle();
        i_rst = 1'b1;
        tick;
        check_quiet("abort");
        i_rst = 1'b0;
        tick;
        run_job(4, 0, 0, 0, 0, 0, 0, mk(6, 10), 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multiexp_dispatch.md
# multiexp_dispatch

Parametrised work distributor and result reducer for the BN128 multi-exponentiation datapath. It accepts a stream of (point, scalar) pairs and deals them round-robin across `NUM_CORES` multiexp cores. It collects each core's partial Jacobian result and folds the partials through a shared external point adder. The single final result is emitted on an output stream. It sits between the instruction/DDR front end and the multiexp core array inside the multiexp top level.

## Interface
- `NUM_CORES`, 4: number of downstream cores, 1..16.
- `POINT_BITS`, 512: affine input point width (x,y, 256 each).
- `SCALAR_BITS`, 256: scalar width.
- `RES_BITS`, 768: Jacobian result width (x,y,z).
- `CNT_BITS`, 32: pair-counter width.

- `i_clk` in 1: clock. One clock domain only.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: one-cycle pulse; latches `i_num_pairs`. Ignored unless IDLE.
- `i_num_pairs` in CNT_BITS: total pairs for this job.
- `o_busy` out 1: high in every state except IDLE.
- `i_pair_val`, `o_pair_rdy`, `i_pair_point[POINT_BITS]`, `i_pair_scalar[SCALAR_BITS]`: input pair stream.
- `o_core_val` out NUM_CORES: per-core valid, one-hot or zero.
- `i_core_rdy` in NUM_CORES: per-core ready.
- `o_core_point`, `o_core_scalar` out: shared bus to all cores.
- `o_core_last` out 1: marks the final pair for the addressed core.
- `i_cres_val` in NUM_CORES, `o_cres_rdy` out NUM_CORES, `i_cres_point` in NUM_CORES*RES_BITS: per-core partial results.
- `o_add_val` out 1, `i_add_rdy` in 1, `o_add_a`/`o_add_b` out RES_BITS: adder request.
- `i_add_res_val` in 1, `i_add_res` in RES_BITS: adder response. Always accepted.
- `o_res_val` out 1, `i_res_rdy` in 1, `o_res_point` out RES_BITS: final result.

## Operation
- States: IDLE → DISPATCH → COLLECT → REDUCE → OUTPUT → IDLE.
- IDLE:
  - On `i_start` with `i_num_pairs`==0, go directly to OUTPUT with the result set to all-zero, which encodes the point at infinity.
  - On `i_start` otherwise, go to DISPATCH.
- DISPATCH, for pair index k from 0 to N-1:
  - Target core is sel = k mod NUM_CORES.
  - `o_pair_rdy` = `i_core_rdy[sel]`.
  - `o_core_val[sel]` = `i_pair_val`; all other bits are 0.
  - Data passes combinationally from the input pair bus to the core bus.
  - `o_core_last` = (k >= N - NUM_CORES).
  - Strict order: a stalled target core stalls the whole stream. No skipping to another core.
  - Each transfer (val&rdy) increments k and advances sel, with wrap to 0.
  - The transfer at k = N-1 moves the FSM to COLLECT.
- Used-core mask: bit c is set iff c < min(N, NUM_CORES). Unused cores are never waited on.
- COLLECT:
  - `o_cres_rdy[c]` is high for each used core whose result is not yet stored.
  - Results are accepted in any order; several may be accepted in one cycle. Each is stored in slot c.
  - When every used core has delivered, go to REDUCE.
- REDUCE:
  - acc = slot 0.
  - For c = 1 to used-1, in order:
    - Hold `o_add_val` with a=acc, b=slot c until `i_add_rdy`.
    - Then wait for `i_add_res_val` and set acc = `i_add_res`.
  - Exactly one request is outstanding at a time.
  - With a single used core, go to OUTPUT with no adds.
- OUTPUT:
  - `o_res_val` is high and `o_res_point` = acc, both held stable until `i_res_rdy`.
  - Return to IDLE on the cycle after the handshake.
- Width rules:
  - k and N are CNT_BITS unsigned.
  - N - NUM_CORES is computed saturating at 0, so every pair is `last` when N <= NUM_CORES.
- Out-of-protocol inputs are ignored:
  - `i_cres_val` from an unused or already-stored core.
  - `i_add_res_val` while no request is outstanding.
  - `i_start` while busy.

## Timing
- Reset values:
  - FSM is IDLE.
  - `o_busy`, `o_pair_rdy`, `o_core_val`, `o_core_last`, `o_cres_rdy`, `o_add_val`, `o_res_val` are 0.
  - `o_res_point`, `o_add_a`, `o_add_b`, `o_core_point`, `o_core_scalar` are 0.
  - Counters, masks and slots are cleared.
- `i_rst` asserted in any state aborts the job on the next edge. In-flight core and adder traffic is dropped; the surrounding logic resets the cores alongside.
- `o_busy` rises the cycle after `i_start`.
- Dispatch throughput is 1 pair/cycle when the target core is ready. The input-to-core path has zero latency.
- COLLECT→REDUCE takes 1 cycle after the last result is stored.
- `o_add_val` is registered and rises the cycle after entering REDUCE or after the previous response.
- Latency from the last adder response to `o_res_val` is 1 cycle.
- A result accepted in the same cycle as the dispatch of pair N-1 cannot occur, because cores hold results until after `last`. A bench assertion flags any `i_cres_val` seen during DISPATCH.

## Test plan
- N=8, NUM_CORES=4, all ready:
  - Pairs reach cores 0,1,2,3,0,1,2,3 in 8 consecutive cycles.
  - `o_core_last` is set on k=4..7.
  - 3 adder requests are issued; the output equals the model sum.
- N=2, NUM_CORES=4:
  - Only cores 0 and 1 are used; both pairs carry `last`.
  - Results from cores 2 and 3 are never requested.
  - 1 add is issued.
- N=0: no core or adder traffic; `o_res_point` = 0 is valid 1 cycle after `i_start`.
- Backpressure:
  - `i_core_rdy[1]` is held low for 5 cycles at k=1; the stream stalls, and core 2 receives nothing until core 1 accepts.
  - `i_res_rdy` is held low for 10 cycles; the output stays stable.
- Out-of-order results: cores return 3,0,2,1, with two returning in the same cycle. Adder operands are still presented in slot order 0,1,2,3.
- Reset mid-job: `i_rst` is asserted in REDUCE with one add outstanding. All outputs read 0 next cycle. A fresh N=4 job then completes correctly.
